// File: rtl/btn_pkg.sv
// Shared FSM state encoding, default sizing and one-hot helpers for btn_press_encoder.
package btn_pkg;

    localparam int NBTN_DEF       = 4;
    localparam int CODE_W_DEF     = 2;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int DEB_W_DEF      = 3;

    // Helpers operate on a fixed-width vector; callers zero-extend their snapshot.
    localparam int BTN_MAX        = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } btn_state_e;

    function automatic int onehot_to_idx(input logic [BTN_MAX-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < BTN_MAX; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [BTN_MAX-1:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// NBTN-wide two-flop synchroniser for raw asynchronous button levels, cleared by R.
module btn_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         R,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] bsync_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (R) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    assign bsync_o = s2_q;

endmodule

// File: rtl/btn_press_encoder.sv
// Debounces synchronised player buttons and emits a one-cycle press strobe with the button code.
// Optional macro BTN_MULTI_ERR_EN enables the multi strobe for multi-button snapshots.
module btn_press_encoder
    import btn_pkg::*;
#(
    parameter int NBTN       = NBTN_DEF,
    parameter int CODE_W     = CODE_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic              clk,
    input  logic              R,
    input  logic [NBTN-1:0]   btn,
    input  logic              en,
    output logic              press,
    output logic [CODE_W-1:0] code,
    output logic              multi,
    output logic              busy
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [NBTN-1:0]    bsync;
    btn_state_e         state_q;
    logic [DEB_W-1:0]   cnt_q;
    logic [NBTN-1:0]    snap_q;
    logic               press_q;
    logic               multi_q;
    logic [CODE_W-1:0]  code_q;

    logic [BTN_MAX-1:0] snap_ext;
    logic               snap_onehot;
    logic [CODE_W-1:0]  snap_idx;

    btn_sync #(
        .W (NBTN)
    ) u_sync (
        .clk     (clk),
        .R       (R),
        .btn_i   (btn),
        .bsync_o (bsync)
    );

    assign snap_ext    = BTN_MAX'(snap_q);
    assign snap_onehot = is_onehot(snap_ext);
    assign snap_idx    = CODE_W'(onehot_to_idx(snap_ext));

    // press/multi default low every cycle so each is exactly one cycle wide.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            press_q <= 1'b0;
            multi_q <= 1'b0;
            code_q  <= '0;
        end else begin
            press_q <= 1'b0;
            multi_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en && (bsync != '0)) begin
                        snap_q  <= bsync;
                        cnt_q   <= '0;
                        state_q <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (bsync != snap_q) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_HELD;
                        if (snap_onehot) begin
                            press_q <= 1'b1;
                            code_q  <= snap_idx;
                        end
`ifdef BTN_MULTI_ERR_EN
                        else begin
                            multi_q <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    // Extra buttons joining an accepted press are deliberately ignored.
                    if (bsync == '0) begin
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (bsync != '0) begin
                        cnt_q   <= '0;
                        state_q <= ST_HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign press = press_q;
    assign multi = multi_q;
    assign code  = code_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_btn_press_encoder.sv
// Directed bench for btn_press_encoder: latency, glitch rejection, multi, bounce, arming and reset.
module tb_btn_press_encoder;

    logic       clk;
    logic       R;
    logic [3:0] btn;
    logic       en;
    logic       press;
    logic [1:0] code;
    logic       multi;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];

    btn_press_encoder dut (
        .clk   (clk),
        .R     (R),
        .btn   (btn),
        .en    (en),
        .press (press),
        .code  (code),
        .multi (multi),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every press strobe must match the next code the directed steps announced.
    always @(negedge clk) begin
        if (press === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_press", 32'(code), 32'hFFFF_FFFF);
            end else begin
                check("sb_press_code", 32'(code), 32'(exp_q.pop_front()));
            end
        end
    end

    // Release from HELD: press-side edge count gives RELEASE after edge 3, IDLE after edge 7.
    task automatic release_check(input string tag);
        btn = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check({tag, "_busy"}, 32'(busy), 32'(k < 7));
            check({tag, "_press"}, 32'(press), 32'd0);
        end
    endtask

    initial begin
        logic exp_multi;
        R   = 1'b1;
        en  = 1'b0;
        btn = 4'b0000;
        tick();
        tick();
        check("rst_press", 32'(press), 32'd0);
        check("rst_code", 32'(code), 32'd0);
        check("rst_multi", 32'(multi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        R = 1'b0;
        tick();

        // Single press of button 2: strobe after edge 7.
        en  = 1'b1;
        btn = 4'b0100;
        exp_q.push_back(2'd2);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("t1_press", 32'(press), 32'(k == 7));
            check("t1_multi", 32'(multi), 32'd0);
            check("t1_busy", 32'(busy), 32'(k >= 3));
            if (k == 7) check("t1_code", 32'(code), 32'd2);
        end
        release_check("t1_rel");

        // Glitch: three synced cycles of button 0 then drop.
        btn = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) btn = 4'b0000;
            check("t2_press", 32'(press), 32'd0);
            check("t2_busy", 32'(busy), 32'(k >= 3 && k <= 5));
        end
        check("t2_state", 32'(dut.state_q), 32'd0);
        check("t2_code", 32'(code), 32'd2);

        // Two buttons together: multi (when enabled), never press, code kept.
        btn = 4'b0011;
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef BTN_MULTI_ERR_EN
            exp_multi = (k == 7);
`else
            exp_multi = 1'b0;
`endif
            check("t3_multi", 32'(multi), 32'(exp_multi));
            check("t3_press", 32'(press), 32'd0);
        end
        check("t3_code", 32'(code), 32'd2);
        check("t3_state", 32'(dut.state_q), 32'd2);
        release_check("t3_rel");

        // Button 3 press, then bouncy release.
        btn = 4'b1000;
        exp_q.push_back(2'd3);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("t4_press", 32'(press), 32'(k == 7));
            if (k == 7) check("t4_code", 32'(code), 32'd3);
        end
        for (int k = 1; k <= 12; k++) begin
            logic [1:0] exp_st;
            btn = (k == 3) ? 4'b1000 : 4'b0000;
            tick();
            exp_st = (k <= 2) ? 2'd2 : (k <= 4) ? 2'd3 : (k == 5) ? 2'd2 : (k <= 9) ? 2'd3 : 2'd0;
            check("t4_state", 32'(dut.state_q), 32'(exp_st));
            check("t4_press", 32'(press), 32'd0);
        end
        check("t4_busy_end", 32'(busy), 32'd0);

        // Disarmed: held button ignored, then accepted once armed.
        en  = 1'b0;
        btn = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t5_off_press", 32'(press), 32'd0);
            check("t5_off_busy", 32'(busy), 32'd0);
        end
        en = 1'b1;
        exp_q.push_back(2'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t5_on_press", 32'(press), 32'(k == 5));
            if (k == 5) check("t5_code", 32'(code), 32'd1);
        end
        release_check("t5_rel");

        // Reset during DEBOUNCE discards the press.
        btn = 4'b0100;
        for (int k = 1; k <= 4; k++) tick();
        check("t6_pre_busy", 32'(busy), 32'd1);
        R = 1'b1;
        tick();
        R   = 1'b0;
        btn = 4'b0000;
        check("t6_press", 32'(press), 32'd0);
        check("t6_code", 32'(code), 32'd0);
        check("t6_multi", 32'(multi), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t6_after_press", 32'(press), 32'd0);
            check("t6_after_busy", 32'(busy), 32'd0);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_press_encoder.md
Name: btn_press_encoder

Overview:
- Input stage that sits directly upstream of the user round counter.
- Takes raw asynchronous player buttons and synchronises and debounces them.
- Encodes a single pressed button into a binary code and issues a one-cycle press strobe that drives the counter's enable (E) input.
- Rejects simultaneous multi-button presses and ignores presses while disarmed.

Parameters:
NBTN, 4, number of player buttons (one-hot inputs)
CODE_W, 2, width of encoded button index; must satisfy 2**CODE_W >= NBTN
DEB_CYCLES, 4, consecutive stable synced cycles required to accept a press or a release; minimum 1
DEB_W, 3, debounce counter width; must hold DEB_CYCLES-1

Ports:
clk  in  1  system clock
R  in  1  reset; synchronous, active-high
btn  in  NBTN  raw asynchronous button levels, 1 = pressed
en  in  1  arm; new presses are accepted only while high
press  out  1  one-cycle strobe, valid single press accepted
code  out  CODE_W  index of accepted button; holds until next accepted press
multi  out  1  one-cycle strobe, more than one button in accepted snapshot
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (R=1 at posedge clk):
  - Both synchroniser stages clear to 0; FSM goes to IDLE; debounce counter and snapshot clear to 0.
  - press=0, code=0, multi=0, busy=0.
  - R has priority over every other event; a press in flight is discarded with no strobe.
- Synchroniser: 2-flop per bit; bsync is the second stage. All FSM decisions use bsync only.
- IDLE:
  - If en=1 and bsync!=0: capture snapshot=bsync, clear cnt, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - If bsync!=snapshot: go to IDLE, no strobe.
  - Else if cnt==DEB_CYCLES-1: go to HELD. If snapshot is one-hot, pulse press and load code with the index of the set bit. If snapshot has more than one bit set, pulse multi, leave code unchanged, no press.
  - Else cnt+1.
- HELD:
  - If bsync==0: clear cnt, go to RELEASE.
  - Additional buttons pressed while in HELD are ignored.
- RELEASE:
  - If bsync!=0: go to HELD.
  - Else if cnt==DEB_CYCLES-1: go to IDLE.
  - Else cnt+1.
- Latency: btn stable from edge 0 makes press high in the cycle after edge 3+DEB_CYCLES (edge 7 at default). press and multi are registered, exactly 1 cycle wide, and mutually exclusive.
- en:
  - Sampled only in IDLE.
  - Dropping en mid-operation does not abort DEBOUNCE, HELD or RELEASE; the in-flight press still strobes.
  - Holding a button while en rises starts a press at the next IDLE evaluation.
- One press strobe per physical press. Re-arming requires a full debounced release.
- Counter wrap: cnt never exceeds DEB_CYCLES-1 and is cleared on every state entry.

Optional Feature:
Macro BTN_MULTI_ERR_EN.
- Defined: multi behaves as specified above.
- Undefined: multi is tied to 0 and a multi-bit snapshot completes DEBOUNCE silently into HELD (no strobe, code unchanged). Port list is unchanged.

Decomposition:
- Shared package btn_pkg holds:
  - FSM state encoding: IDLE=2'd0, DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3.
  - Default NBTN/CODE_W/DEB_CYCLES constants.
  - One-hot-to-index function and one-hot check function.
- One natural sub-module: btn_sync, the parameterised NBTN-wide 2-flop synchroniser with synchronous reset on R.

Test Plan:
- Reset, en=1, btn=4'b0100 held 20 cycles: press high exactly 1 cycle after edge 7, code=2'd2, multi=0, busy=1 until release.
- btn=4'b0001 for 3 synced cycles, then glitch to 0: no press, FSM returns to IDLE, busy falls.
- btn=4'b0011 held 20 cycles: multi=1 for 1 cycle with the macro defined (0 without it), press=0, code keeps prior value.
- Press 4'b1000, release with 2-cycle bounce (0, then 1000 for 1 cycle, then 0 held): exactly one press, code=2'd3. FSM goes RELEASE, HELD, RELEASE, then IDLE after 4 clean zero cycles.
- en=0 with btn=4'b0010 held: no press, busy=0. Raise en with the button still held: press follows, code=2'd1.
- R=1 asserted mid-DEBOUNCE for 1 cycle, btn then released: all outputs 0, no press strobe.
